re_name_multi: RTL and testbench
================================

Name: re_name_multi

Overview:
- Parametrised successor to the single-bit GPR/FPR renamer between scoreboard and issue/read-operands.
- Each architectural register (GPR and FPR tables) gets a NAME_BITS-wide name counter instead of a toggle bit, giving 2^NAME_BITS physical names per register.
- Tracks in-flight (issued, uncommitted) writers per register and stalls issue when a register has no free name left.
- A commit port releases names.

Parameters:
NR_ARCH_REGS, 32, architectural registers per file; ARCH_W = $clog2(NR_ARCH_REGS)
NAME_BITS, 2, name counter width; NR_NAMES = 2^NAME_BITS; legal range 1..3
ENABLE_RENAME, 1, 0 = all name fields forced to 0, no stall, tables still maintained

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  clear all rename state
flush_unissued_instr_i  in  1  suppress table update for current handshake
issue_valid_i  in  1  instruction valid from scoreboard
issue_ack_o  out  1  ack to scoreboard
issue_rs1_i / issue_rs2_i  in  ARCH_W each  source addresses
issue_rs1_fpr_i / issue_rs2_fpr_i  in  1 each  source is FPR
issue_rs3_valid_i  in  1  third FPR operand present
issue_rs3_i  in  ARCH_W  third operand address (always FPR)
issue_rd_i  in  ARCH_W  destination
issue_rd_fpr_i  in  1  destination is FPR
issue_rd_we_i  in  1  instruction writes rd
issue_valid_o  out  1  valid to issue stage
issue_ack_i  in  1  ack from issue stage
rs1_o / rs2_o / rs3_o / rd_o  out  NAME_BITS+ARCH_W each  {name, arch addr}
stall_o  out  1  rename stall (no free name)
commit_valid_i  in  1  a writer commits
commit_rd_i  in  ARCH_W  committed destination
commit_fpr_i  in  1  committed destination is FPR

Behaviour:
- State per file per register: name_q[NAME_BITS], inflight_q[NAME_BITS+1]. Reset and flush: all 0.
- Outputs combinational from inputs and state; no added latency.
- GPR x0 never renamed: rd_o name 0, never counted, never stalls.
- Sources: rs1_o = {name_q[file][rs1], rs1}; rs2_o likewise. rs3_o = {fpr name_q[rs3], rs3} when rs3_valid, else {0, rs3}.
- Renamed writer: rd_we_i=1 and not GPR x0. For a renamed writer, rd_o = {name_q[rd]+1 mod NR_NAMES, rd}. Otherwise rd_o = {0, rd}.
- Stall:
  - stall_o = ENABLE_RENAME & issue_valid_i & renamed writer & inflight_q[rd] == NR_NAMES-1.
  - Commit in the same cycle to the same register and file does not clear the stall (registered release only).
- Handshake:
  - issue_valid_o = issue_valid_i & ~stall_o.
  - issue_ack_o = issue_ack_i & ~stall_o.
- Issue event: issue_ack_o & issue_valid_i & renamed writer & ~flush_unissued_instr_i.
  - On issue: name_q[rd] += 1 (wraps mod NR_NAMES) and inflight_q[rd] += 1.
- Commit event: commit_valid_i & not GPR x0 → inflight_q[commit_rd] -= 1.
  - Commit with inflight 0 is illegal: assertion fires, counter held at 0.
- Issue and commit to the same register in the same cycle: name advances, inflight unchanged.
- flush_i has priority over issue and commit in the same cycle: all state is 0 next cycle.
- Asynchronous reset mid-operation: all state 0 immediately; outputs reflect zero names.
- ENABLE_RENAME=0: name fields of all outputs are 0 and stall_o=0. Counters still update, so toggling the parameter never changes handshake timing except via the stall.

Test Plan:
- Reset, issue GPR rd=5 writer with ack → rd_o={1,5}. Next cycle a source rs1=5 → rs1_o={1,5}, inflight[5]=1.
- NAME_BITS=2: three writers to rd=7 without commit → rd_o names 1,2,3. The fourth asserts stall_o with issue_valid_o=0 and issue_ack_o=0. A commit of rd=7 frees it next cycle, and the fourth issues with name 0 (wrap).
- Writer rd=0 (GPR) repeated 10 times → rd_o={0,0}, never stalls. FPR rd=0 writer → name 1.
- Issue rd=3 plus commit rd=3 in the same cycle with inflight=1 → name 2, inflight stays 1. Issue with flush_unissued_instr_i=1 → no state change.
- FMA with rs3_valid, rs3=4 after FPR f4 written twice → rs3_o={2,4}. GPR x4 name stays 0 (files independent).
- Three writers in flight, then flush_i with a simultaneous issue → all names and inflight 0. Async reset asserted mid-stall → stall_o=0 immediately.

Source files
------------

// File: rtl/re_name_multi_if.sv
// Scoreboard/issue handshake, operand addresses and commit port of the multi-bit register renamer.
// The slave modport faces the renamer; the master modport faces the surrounding pipeline.
interface re_name_multi_if #(
  parameter int unsigned ARCH_W    = 5,
  parameter int unsigned NAME_BITS = 2
);
  logic                        flush_i;
  logic                        flush_unissued_instr_i;
  logic                        issue_valid_i;
  logic                        issue_ack_o;
  logic [ARCH_W-1:0]           issue_rs1_i;
  logic [ARCH_W-1:0]           issue_rs2_i;
  logic                        issue_rs1_fpr_i;
  logic                        issue_rs2_fpr_i;
  logic                        issue_rs3_valid_i;
  logic [ARCH_W-1:0]           issue_rs3_i;
  logic [ARCH_W-1:0]           issue_rd_i;
  logic                        issue_rd_fpr_i;
  logic                        issue_rd_we_i;
  logic                        issue_valid_o;
  logic                        issue_ack_i;
  logic [NAME_BITS+ARCH_W-1:0] rs1_o;
  logic [NAME_BITS+ARCH_W-1:0] rs2_o;
  logic [NAME_BITS+ARCH_W-1:0] rs3_o;
  logic [NAME_BITS+ARCH_W-1:0] rd_o;
  logic                        stall_o;
  logic                        commit_valid_i;
  logic [ARCH_W-1:0]           commit_rd_i;
  logic                        commit_fpr_i;

  modport slave (
    input  flush_i, flush_unissued_instr_i, issue_valid_i, issue_rs1_i, issue_rs2_i,
           issue_rs1_fpr_i, issue_rs2_fpr_i, issue_rs3_valid_i, issue_rs3_i, issue_rd_i,
           issue_rd_fpr_i, issue_rd_we_i, issue_ack_i, commit_valid_i, commit_rd_i, commit_fpr_i,
    output issue_ack_o, issue_valid_o, rs1_o, rs2_o, rs3_o, rd_o, stall_o
  );

  modport master (
    output flush_i, flush_unissued_instr_i, issue_valid_i, issue_rs1_i, issue_rs2_i,
           issue_rs1_fpr_i, issue_rs2_fpr_i, issue_rs3_valid_i, issue_rs3_i, issue_rd_i,
           issue_rd_fpr_i, issue_rd_we_i, issue_ack_i, commit_valid_i, commit_rd_i, commit_fpr_i,
    input  issue_ack_o, issue_valid_o, rs1_o, rs2_o, rs3_o, rd_o, stall_o
  );
endinterface

// File: rtl/re_name_multi.sv
// GPR/FPR renamer with a NAME_BITS name counter and in-flight writer count per register; zero-latency outputs.
// Backpressure: a writer whose register already has NR_NAMES-1 uncommitted writers stalls both handshake directions.
module re_name_multi #(
  parameter int unsigned NR_ARCH_REGS  = 32,
  parameter int unsigned NAME_BITS     = 2,
  parameter bit          ENABLE_RENAME = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  re_name_multi_if.slave bus
);
  localparam int unsigned ARCH_W   = $clog2(NR_ARCH_REGS);
  localparam int unsigned NR_NAMES = 1 << NAME_BITS;
  localparam int unsigned INF_W    = NAME_BITS + 1;

  typedef logic [NAME_BITS-1:0] name_t;
  typedef logic [INF_W-1:0]     inf_t;

  localparam name_t NAME_MASK = ENABLE_RENAME ? '1 : '0;

  // index 0 = GPR file, 1 = FPR file
  name_t name_q     [2][NR_ARCH_REGS];
  inf_t  inflight_q [2][NR_ARCH_REGS];

  logic  rd_renamed;
  logic  commit_renamed;
  logic  stall;
  logic  ack;
  logic  issue_evt;
  inf_t  rd_inflight;
  name_t rd_name;
  name_t rs1_name;
  name_t rs2_name;
  name_t rs3_name;
  logic  issue_sel  [2][NR_ARCH_REGS];
  logic  commit_sel [2][NR_ARCH_REGS];

  // GPR x0 is hardwired zero, so writes to it never take a name
  assign rd_renamed     = bus.issue_rd_we_i & (bus.issue_rd_fpr_i | (bus.issue_rd_i != '0));
  assign commit_renamed = bus.commit_valid_i & (bus.commit_fpr_i | (bus.commit_rd_i != '0));

  assign rd_inflight = inflight_q[bus.issue_rd_fpr_i][bus.issue_rd_i];
  assign stall       = ENABLE_RENAME & bus.issue_valid_i & rd_renamed
                     & (rd_inflight == inf_t'(NR_NAMES - 1));
  assign ack         = bus.issue_ack_i & ~stall;
  assign issue_evt   = ack & bus.issue_valid_i & rd_renamed & ~bus.flush_unissued_instr_i;

  assign rd_name  = rd_renamed ? name_q[bus.issue_rd_fpr_i][bus.issue_rd_i] + name_t'(1) : '0;
  assign rs1_name = name_q[bus.issue_rs1_fpr_i][bus.issue_rs1_i];
  assign rs2_name = name_q[bus.issue_rs2_fpr_i][bus.issue_rs2_i];
  assign rs3_name = bus.issue_rs3_valid_i ? name_q[1][bus.issue_rs3_i] : '0;

  assign bus.rs1_o         = {rs1_name & NAME_MASK, bus.issue_rs1_i};
  assign bus.rs2_o         = {rs2_name & NAME_MASK, bus.issue_rs2_i};
  assign bus.rs3_o         = {rs3_name & NAME_MASK, bus.issue_rs3_i};
  assign bus.rd_o          = {rd_name & NAME_MASK, bus.issue_rd_i};
  assign bus.stall_o       = stall;
  assign bus.issue_valid_o = bus.issue_valid_i & ~stall;
  assign bus.issue_ack_o   = ack;

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
        issue_sel[f][r]  = issue_evt && (bus.issue_rd_fpr_i == 1'(f))
                         && (bus.issue_rd_i == ARCH_W'(r));
        commit_sel[f][r] = commit_renamed && (bus.commit_fpr_i == 1'(f))
                         && (bus.commit_rd_i == ARCH_W'(r));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
          name_q[f][r]     <= '0;
          inflight_q[f][r] <= '0;
        end
      end
    end else if (bus.flush_i) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
          name_q[f][r]     <= '0;
          inflight_q[f][r] <= '0;
        end
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
          if (issue_sel[f][r]) begin
            name_q[f][r] <= name_q[f][r] + name_t'(1);
          end
          // simultaneous issue and commit to one register leaves the count as is
          case ({issue_sel[f][r], commit_sel[f][r]})
            2'b10: if (inflight_q[f][r] != '1) inflight_q[f][r] <= inflight_q[f][r] + inf_t'(1);
            2'b01: if (inflight_q[f][r] != '0) inflight_q[f][r] <= inflight_q[f][r] - inf_t'(1);
            default: ;
          endcase
        end
      end
    end
  end

  // a commit must always retire a writer that was issued earlier
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (commit_renamed && !bus.flush_i && !(issue_evt && bus.issue_rd_fpr_i == bus.commit_fpr_i
                                          && bus.issue_rd_i == bus.commit_rd_i))
    |-> (inflight_q[bus.commit_fpr_i][bus.commit_rd_i] != '0));

endmodule

// File: tb/tb_re_name_multi.sv
// Directed bench for re_name_multi: per-register issue/commit totals model every output each cycle,
// and literal expectations pin the model at the scenarios of interest.
module tb_re_name_multi;
  localparam int NR = 32;
  localparam int NB = 2;
  localparam int AW = 5;
  localparam int NN = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  re_name_multi_if #(.ARCH_W(AW), .NAME_BITS(NB)) bus ();

  re_name_multi #(
    .NR_ARCH_REGS (NR),
    .NAME_BITS    (NB),
    .ENABLE_RENAME(1'b1)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: total issued and committed writers per register since the last reset/flush
  int iss [2][NR];
  int com [2][NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int name, input int addr);
    return 32'((name << AW) | addr);
  endfunction

  function automatic bit is_renamed(input bit we, input bit fpr, input int rd);
    return we && (fpr || rd != 0);
  endfunction

  task automatic model_clear();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NR; r++) begin
        iss[f][r] = 0;
        com[f][r] = 0;
      end
  endtask

  task automatic model_step();
    int  f, rd, cf, cr;
    bit  ren, e_stall, issued;
    logic [31:0] e_rd, e_rs1, e_rs2, e_rs3;
    f   = int'(bus.issue_rd_fpr_i);
    rd  = int'(bus.issue_rd_i);
    ren = is_renamed(bus.issue_rd_we_i, bus.issue_rd_fpr_i, rd);
    e_stall = bus.issue_valid_i && ren && (iss[f][rd] - com[f][rd] == NN - 1);
    e_rd  = ren ? mk((iss[f][rd] + 1) % NN, rd) : mk(0, rd);
    e_rs1 = mk(iss[int'(bus.issue_rs1_fpr_i)][int'(bus.issue_rs1_i)] % NN, int'(bus.issue_rs1_i));
    e_rs2 = mk(iss[int'(bus.issue_rs2_fpr_i)][int'(bus.issue_rs2_i)] % NN, int'(bus.issue_rs2_i));
    e_rs3 = bus.issue_rs3_valid_i ? mk(iss[1][int'(bus.issue_rs3_i)] % NN, int'(bus.issue_rs3_i))
                                  : mk(0, int'(bus.issue_rs3_i));
    chk("m_stall", bus.stall_o, e_stall);
    chk("m_valid_o", bus.issue_valid_o, bus.issue_valid_i && !e_stall);
    chk("m_ack_o", bus.issue_ack_o, bus.issue_ack_i && !e_stall);
    chk("m_rd", bus.rd_o, e_rd);
    chk("m_rs1", bus.rs1_o, e_rs1);
    chk("m_rs2", bus.rs2_o, e_rs2);
    chk("m_rs3", bus.rs3_o, e_rs3);
    if (bus.flush_i) begin
      model_clear();
    end else begin
      issued = bus.issue_valid_i && bus.issue_ack_i && !e_stall && ren && !bus.flush_unissued_instr_i;
      if (issued) iss[f][rd]++;
      cf = int'(bus.commit_fpr_i);
      cr = int'(bus.commit_rd_i);
      if (bus.commit_valid_i && is_renamed(1'b1, bus.commit_fpr_i, cr) && (iss[cf][cr] - com[cf][cr] > 0))
        com[cf][cr]++;
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      model_clear();
      chk("rst_stall", bus.stall_o, 1'b0);
      chk("rst_valid_o", bus.issue_valid_o, bus.issue_valid_i);
    end else begin
      model_step();
    end
  end

  task automatic idle();
    bus.flush_i = 0; bus.flush_unissued_instr_i = 0;
    bus.issue_valid_i = 0; bus.issue_ack_i = 0;
    bus.issue_rs1_i = '0; bus.issue_rs2_i = '0; bus.issue_rs3_i = '0; bus.issue_rd_i = '0;
    bus.issue_rs1_fpr_i = 0; bus.issue_rs2_fpr_i = 0; bus.issue_rs3_valid_i = 0;
    bus.issue_rd_fpr_i = 0; bus.issue_rd_we_i = 0;
    bus.commit_valid_i = 0; bus.commit_rd_i = '0; bus.commit_fpr_i = 0;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic wr(input bit fpr, input int rd);
    bus.issue_valid_i = 1; bus.issue_ack_i = 1; bus.issue_rd_we_i = 1;
    bus.issue_rd_fpr_i = fpr; bus.issue_rd_i = AW'(rd);
  endtask

  task automatic cm(input bit fpr, input int rd);
    bus.commit_valid_i = 1; bus.commit_fpr_i = fpr; bus.commit_rd_i = AW'(rd);
  endtask

  initial begin
    idle();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;

    // first rename of x5 and its use as a source
    bus.issue_rs1_i = 5;
    @(negedge clk_i); chk("reset_rs1", bus.rs1_o, mk(0, 5));
    next(); wr(0, 5);
    @(negedge clk_i); chk("rd5_name", bus.rd_o, mk(1, 5)); chk("rd5_valid", bus.issue_valid_o, 1);
    next(); bus.issue_rs1_i = 5;
    @(negedge clk_i); chk("rs1_x5", bus.rs1_o, mk(1, 5));

    // exhaust names of x7, commit in the stall cycle, then wrap
    for (int i = 1; i <= 3; i++) begin
      next(); wr(0, 7);
      @(negedge clk_i); chk("rd7_name", bus.rd_o, mk(i, 7));
    end
    next(); wr(0, 7); cm(0, 7);
    @(negedge clk_i);
    chk("rd7_stall", bus.stall_o, 1); chk("rd7_valid_o", bus.issue_valid_o, 0);
    chk("rd7_ack_o", bus.issue_ack_o, 0);
    next(); wr(0, 7);
    @(negedge clk_i); chk("rd7_free", bus.stall_o, 0); chk("rd7_wrap", bus.rd_o, mk(0, 7));

    // x0 is never renamed, f0 is
    for (int i = 0; i < 10; i++) begin
      next(); wr(0, 0);
      @(negedge clk_i); chk("x0_rd", bus.rd_o, mk(0, 0)); chk("x0_stall", bus.stall_o, 0);
    end
    next(); wr(1, 0);
    @(negedge clk_i); chk("f0_rd", bus.rd_o, mk(1, 0));

    // issue+commit to x3 in one cycle keeps one writer in flight
    next(); wr(0, 3);
    @(negedge clk_i); chk("x3_first", bus.rd_o, mk(1, 3));
    next(); wr(0, 3); cm(0, 3);
    @(negedge clk_i); chk("x3_same_cyc", bus.rd_o, mk(2, 3));
    next(); wr(0, 3);
    @(negedge clk_i); chk("x3_third", bus.rd_o, mk(3, 3)); chk("x3_nostall", bus.stall_o, 0);
    next(); wr(0, 3);
    @(negedge clk_i); chk("x3_fourth", bus.rd_o, mk(0, 3));
    next(); wr(0, 3);
    @(negedge clk_i); chk("x3_full", bus.stall_o, 1);
    next(); wr(0, 9); bus.flush_unissued_instr_i = 1;
    @(negedge clk_i); chk("x9_unissued_rd", bus.rd_o, mk(1, 9));
    next(); bus.issue_rs1_i = 9;
    @(negedge clk_i); chk("x9_unchanged", bus.rs1_o, mk(0, 9));

    // third FPR operand and file independence
    next(); wr(1, 4);
    next(); wr(1, 4);
    next();
    bus.issue_rs3_valid_i = 1; bus.issue_rs3_i = 4;
    bus.issue_rs1_i = 4; bus.issue_rs2_i = 4; bus.issue_rs2_fpr_i = 1;
    @(negedge clk_i);
    chk("f4_rs3", bus.rs3_o, mk(2, 4)); chk("x4_rs1", bus.rs1_o, mk(0, 4));
    chk("f4_rs2", bus.rs2_o, mk(2, 4));
    next(); bus.issue_rs3_i = 4;
    @(negedge clk_i); chk("rs3_invalid", bus.rs3_o, mk(0, 4));

    // flush wins over a simultaneous issue
    for (int i = 0; i < 3; i++) begin
      next(); wr(0, 10);
    end
    next(); wr(0, 11); bus.flush_i = 1;
    next(); wr(0, 10); bus.issue_rs1_i = 10; bus.issue_rs2_i = 11;
    @(negedge clk_i);
    chk("flush_x10", bus.rs1_o, mk(0, 10)); chk("flush_x11", bus.rs2_o, mk(0, 11));
    chk("flush_rd10", bus.rd_o, mk(1, 10)); chk("flush_nostall", bus.stall_o, 0);
    next(); bus.issue_rs1_i = 7;
    @(negedge clk_i); chk("flush_x7", bus.rs1_o, mk(0, 7));

    // asynchronous reset in the middle of a stall
    for (int i = 0; i < 3; i++) begin
      next(); wr(0, 12);
    end
    next(); wr(0, 12);
    @(negedge clk_i); chk("x12_stall", bus.stall_o, 1);
    @(posedge clk_i); #2;
    rst_ni = 0;
    #1;
    chk("arst_stall", bus.stall_o, 0); chk("arst_rd", bus.rd_o, mk(1, 12));
    chk("arst_valid", bus.issue_valid_o, 1);
    @(posedge clk_i); #1;
    rst_ni = 1;
    idle(); wr(0, 12);
    @(negedge clk_i); chk("post_rst_rd", bus.rd_o, mk(1, 12));
    next();
    @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
